// File: rtl/claw_round_controller.sv
// Claw game round sequencer: start/ready countdown, round timer, scoring, drain, high score.
// Latency: one cycle from any sampled input pulse to the registered outputs.
// Backpressure: none; pulses are consumed the cycle they arrive, start pre-empts everything.
module claw_round_controller #(
  parameter int ROUND_SECONDS = 60,
  parameter int READY_SECONDS = 3,
  parameter int DRAIN_SECONDS = 5,
  parameter int TIME_W        = 8,
  parameter int SCORE_W       = 16
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               tick_i,
  input  logic               score_pulse_i,
  input  logic               claw_busy_i,
  output logic               game_active_o,
  output logic [TIME_W-1:0]  time_left_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] high_score_o,
  output logic [2:0]         phase_o,
  output logic               round_done_o,
  output logic               new_high_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int DRAIN_W = $clog2(DRAIN_SECONDS + 1);

  logic [2:0]         state_q, state_d;
  logic [TIME_W-1:0]  time_left_q, time_left_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               game_active_q, game_active_d;
  logic [2:0]         phase_q, phase_d;
  logic               round_done_q, round_done_d;
  logic               new_high_q, new_high_d;
  logic               enter_over;
  logic [SCORE_W-1:0] score_bumped;

  // Saturating increment, only used where score pulses are credited.
  always_comb begin
    score_bumped = score_q;
    if (score_pulse_i && (score_q != {SCORE_W{1'b1}})) begin
      score_bumped = score_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    time_left_d  = time_left_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    drain_cnt_d  = drain_cnt_q;
    round_done_d = 1'b0;
    new_high_d   = 1'b0;
    enter_over   = 1'b0;

    if (start_i) begin
      state_d     = S_READY;
      time_left_d = TIME_W'(READY_SECONDS);
      score_d     = '0;
    end else begin
      case (state_q)
        S_READY: begin
          // time_left doubles as the ready countdown
          if (tick_i) begin
            if (time_left_q == TIME_W'(1)) begin
              state_d     = S_PLAY;
              time_left_d = TIME_W'(ROUND_SECONDS);
            end else begin
              time_left_d = time_left_q - 1'b1;
            end
          end
        end
        S_PLAY: begin
          score_d = score_bumped;
          if (tick_i) begin
            if (time_left_q == TIME_W'(1)) begin
              time_left_d = '0;
              if (claw_busy_i) begin
                state_d     = S_DRAIN;
                drain_cnt_d = '0;
              end else begin
                enter_over = 1'b1;
              end
            end else begin
              time_left_d = time_left_q - 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // A drop started before the buzzer still earns its point.
          score_d = score_bumped;
          if (tick_i) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
          if (!claw_busy_i ||
              (tick_i && (drain_cnt_q == DRAIN_W'(DRAIN_SECONDS - 1)))) begin
            enter_over = 1'b1;
          end
        end
        S_IDLE, S_OVER: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (enter_over) begin
      state_d      = S_OVER;
      round_done_d = 1'b1;
      if (score_d > high_score_q) begin
        high_score_d = score_d;
        new_high_d   = 1'b1;
      end
    end

    game_active_d = (state_d == S_PLAY);
    phase_d       = {state_d == S_OVER, state_d == S_PLAY, state_d == S_READY};
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      time_left_q   <= '0;
      score_q       <= '0;
      high_score_q  <= '0;
      drain_cnt_q   <= '0;
      game_active_q <= 1'b0;
      phase_q       <= 3'b000;
      round_done_q  <= 1'b0;
      new_high_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      time_left_q   <= time_left_d;
      score_q       <= score_d;
      high_score_q  <= high_score_d;
      drain_cnt_q   <= drain_cnt_d;
      game_active_q <= game_active_d;
      phase_q       <= phase_d;
      round_done_q  <= round_done_d;
      new_high_q    <= new_high_d;
    end
  end

  assign game_active_o = game_active_q;
  assign time_left_o   = time_left_q;
  assign score_o       = score_q;
  assign high_score_o  = high_score_q;
  assign phase_o       = phase_q;
  assign round_done_o  = round_done_q;
  assign new_high_o    = new_high_q;

endmodule
